pipo_reg_arbiter: RTL and testbench

Four-requester arbiter and write sequencer for the shared 4-bit PIPO register (PIPOreg_4bits). Requesters raise a request with 4-bit data. The block picks one winner, drives the register's `load`/`data` inputs for exactly one cycle, and acknowledges the winner. After each write it enforces a programmable hold window before the next grant. The block sits between the requester logic and the register instance; register output `Q` is not an input to this block.

---
 rtl/pipo_reg_arbiter.sv | 159 +++++++++++++++
 tb/tb_pipo_reg_arbiter.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/pipo_reg_arbiter.sv
// pipo_reg_arbiter: four-requester arbiter and write sequencer for a shared
// 4-bit PIPO register. One winner per grant; the winner's data is captured at
// the grant edge and presented on data with a single-cycle load/ack pulse,
// followed by a HOLD-cycle quiet window before the next grant.
//
// Build option: define PIPO_ARB_FIXED_PRI_EN for fixed priority (lowest index
// wins). Left undefined, arbitration is round-robin starting after the last
// winner.
//
// HOLD is the number of quiet cycles after each write, legal range 0..15.
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | waiting for a request; grants at the first edge with req != 0
// S_LOAD | load and ack[owner] high for exactly one cycle
// S_HOLD | quiet window, down-counter from HOLD-1 to 0, requests ignored

module pipo_reg_arbiter #(
  parameter int HOLD = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [15:0] data_in,
  output logic [3:0]  ack,
  output logic        load,
  output logic [3:0]  data,
  output logic [1:0]  owner,
  output logic        busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  // Counter preload; a HOLD of 0 never enters S_HOLD, so the value is unused then.
  localparam logic [3:0] HOLD_M1 = (HOLD > 0) ? 4'(HOLD - 1) : 4'd0;
  localparam bit         HAS_HOLD = (HOLD > 0);

  state_t     state;
  state_t     state_nxt;
  logic [3:0] cnt;
  logic [3:0] cnt_nxt;
  logic       grant;
  logic [1:0] winner;
  logic       found;

  assign grant = (state == S_IDLE) && (req != 4'd0);

`ifdef PIPO_ARB_FIXED_PRI_EN
  // Fixed priority: lowest-indexed active requester wins.
  always_comb begin
    winner = 2'd0;
    found  = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && req[i]) begin
        winner = 2'(i);
        found  = 1'b1;
      end
    end
  end
`else
  logic [1:0] last;

  // Round-robin: search starts one past the previous winner and wraps.
  always_comb begin
    logic [1:0] idx;
    winner = 2'd0;
    found  = 1'b0;
    idx    = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!found && req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Previous winner; reset to 3 so requester 0 is searched first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last <= 2'd3;
    end else if (grant) begin
      last <= winner;
    end
  end
`endif

  // State and hold-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic and hold-counter update.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (grant) begin
          state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        if (HAS_HOLD) begin
          state_nxt = S_HOLD;
          cnt_nxt   = HOLD_M1;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_HOLD: begin
        if (cnt == 4'd0) begin
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
    endcase
  end

  // Registered strobes: load/ack pulse for the cycle spent in S_LOAD, busy mirrors non-IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      load <= 1'b0;
      ack  <= 4'd0;
      busy <= 1'b0;
    end else begin
      load <= grant;
      ack  <= grant ? (4'd1 << winner) : 4'd0;
      busy <= (state_nxt != S_IDLE);
    end
  end

  // Capture winner index and data at the grant edge; held until the next grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner <= 2'd0;
      data  <= 4'd0;
    end else if (grant) begin
      owner <= winner;
      data  <= data_in[{winner, 2'b00} +: 4];
    end
  end

endmodule

// File: tb/tb_pipo_reg_arbiter.sv
module tb_pipo_reg_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [15:0] data_in;
  logic [3:0]  ack;
  logic        load;
  logic [3:0]  data;
  logic [1:0]  owner;
  logic        busy;

  typedef struct packed {
    logic [1:0] own;
    logic [3:0] dat;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;
  logic [3:0] q_model;

  pipo_reg_arbiter #(.HOLD(2)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data_in (data_in),
    .ack     (ack),
    .load    (load),
    .data    (data),
    .owner   (owner),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stand-in for the downstream PIPO register.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_model <= 4'd0;
    else if (load) q_model <= data;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] own, input logic [3:0] dat);
    exp_t e;
    e.own = own;
    e.dat = dat;
    sb.push_back(e);
  endtask

  // Monitor: pops one expected grant per load pulse.
  always @(negedge clk) begin
    if (rst_n) begin
      check("ack_load_coincident", {31'd0, (ack != 4'd0)}, {31'd0, load});
      if (load) begin
        if (sb.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_grant actual_owner=%0d actual_data=%0h expected=none", owner, data);
        end else begin
          mon_e = sb.pop_front();
          check("grant_ack",   {28'd0, ack},   {28'd0, 4'd1 << mon_e.own});
          check("grant_owner", {30'd0, owner}, {30'd0, mon_e.own});
          check("grant_data",  {28'd0, data},  {28'd0, mon_e.dat});
          check("grant_busy",  {31'd0, busy},  32'd1);
        end
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int bcnt;
    int nload;
    int n2;
    int times[5];

    // Reset with all requests active.
    rst_n   = 1'b0;
    req     = 4'b1111;
    data_in = 16'($urandom);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("reset_outputs", {20'd0, ack, load, data, owner, busy}, 32'd0);
      data_in = 16'($urandom);
    end
    req   = 4'd0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single request from requester 1, data changes after the grant edge.
    data_in = 16'h00A0;
    req     = 4'b0010;
    push(2'd1, 4'hA);
    @(negedge clk);
    check("single_latency_load", {31'd0, load}, 32'd1);
    req     = 4'd0;
    data_in = 16'hFFFF;
    bcnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) bcnt++;
      if (i == 1) check("single_q", {28'd0, q_model}, 32'hA);
      @(negedge clk);
    end
    check("single_busy_cycles", bcnt, 32'd3);

    // Requests raised only during HOLD are ignored.
    data_in = 16'h0005;
    req     = 4'b0001;
    push(2'd0, 4'h5);
    @(negedge clk);              // LOAD
    req = 4'd0;
    @(negedge clk);              // HOLD 1
    req     = 4'b1000;
    data_in = 16'h7000;
    @(negedge clk);              // HOLD 2
    @(negedge clk);              // IDLE
    check("hold_ends_busy", {31'd0, busy}, 32'd0);
    req = 4'd0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("hold_ignore_noload", {31'd0, load}, 32'd0);
    end
    check("hold_ignore_data", {28'd0, data}, 32'h5);

    // Reset in the first HOLD cycle, then round-robin from requester 0.
    data_in = 16'h00C0;
    req     = 4'b0010;
    push(2'd1, 4'hC);
    @(negedge clk);              // LOAD
    req = 4'd0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("rst_hold_cleared", {23'd0, busy, load, ack, owner}, 32'd0);
    check("rst_hold_data", {28'd0, data}, 32'd0);
    @(negedge clk);
    rst_n   = 1'b1;
    data_in = 16'h4321;
    req     = 4'b1111;
`ifdef PIPO_ARB_FIXED_PRI_EN
    for (int i = 0; i < 5; i++) push(2'd0, 4'h1);
`else
    push(2'd0, 4'h1);
    push(2'd1, 4'h2);
    push(2'd2, 4'h3);
    push(2'd3, 4'h4);
    push(2'd0, 4'h1);
`endif
    @(negedge clk);
    check("rr_first_latency", {31'd0, load}, 32'd1);
    nload = 0;
    for (int i = 0; i < 40 && nload < 5; i++) begin
      if (load) begin
        times[nload] = i;
        nload++;
      end
      if (nload < 5) @(negedge clk);
    end
    req = 4'd0;
    check("rr_grant_count", nload, 32'd5);
    for (int i = 1; i < 5; i++) begin
      if (i < nload) check("rr_grant_period", times[i] - times[i-1], 32'd4);
    end

    // Requesters 0 and 2 held: alternate in round-robin, 0 only with fixed priority.
    data_in = 16'h0903;
    req     = 4'b0101;
`ifdef PIPO_ARB_FIXED_PRI_EN
    for (int i = 0; i < 10; i++) push(2'd0, 4'h3);
`else
    for (int i = 0; i < 5; i++) begin
      push(2'd2, 4'h9);
      push(2'd0, 4'h3);
    end
`endif
    nload = 0;
    n2    = 0;
    for (int i = 0; i < 80 && nload < 10; i++) begin
      @(negedge clk);
      if (load) begin
        nload++;
        if (ack[2]) n2++;
      end
    end
    req = 4'd0;
    check("pri_grant_count", nload, 32'd10);
`ifdef PIPO_ARB_FIXED_PRI_EN
    check("pri_req2_acks", n2, 32'd0);
`else
    check("pri_req2_acks", n2, 32'd5);
`endif

    repeat (6) @(negedge clk);
    check("scoreboard_empty", sb.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
